// File: rtl/mcu_target_arb_pkg.sv
// Shared definitions for the MCU target arbiter: interrupt-controller ID,
// interrupt-controller command codes and decode FSM state encoding.
package mcu_target_arb_pkg;

  localparam logic [7:0] IRQ_ID_DEFAULT = 8'hF0;

  localparam logic [7:0] ICTL_READ  = 8'h00;
  localparam logic [7:0] ICTL_ACK   = 8'h01;
  localparam logic [7:0] ICTL_SETEN = 8'h02;
  localparam logic [7:0] ICTL_GETEN = 8'h03;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_FWD,
    ST_ICTL_CMD,
    ST_ICTL_DATA,
    ST_DISCARD
  } arb_state_t;

  // Commands the interrupt controller understands; anything else is discarded.
  function automatic logic ictl_cmd_valid(input logic [7:0] cmd);
    return (cmd <= ICTL_GETEN);
  endfunction

endpackage

// File: rtl/mcu_irq_ctl.sv
// Interrupt controller: enable mask, pending snapshot / enable readback,
// per-target acknowledge pulses and the merged MCU interrupt line.
module mcu_irq_ctl
  import mcu_target_arb_pkg::*;
#(
  parameter int NTGT = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_strobe,   // command byte while addressed
  input  logic            data_strobe,  // data byte while addressed
  input  logic [7:0]      din,
  input  logic [NTGT-1:0] tgt_irq,
  output logic [7:0]      rdata,
  output logic [NTGT-1:0] tgt_iack,
  output logic            mcu_irq
);

  logic [NTGT-1:0] en_reg;
  logic [NTGT-1:0] iack_reg;
  logic [7:0]      op_reg;
  logic [7:0]      rdata_reg;
  logic            armed_reg;
  logic            irq_reg;
  logic [NTGT-1:0] pend;
  logic [7:0]      rd_pend;
  logic [7:0]      rd_en;

  // Zero-extend the pending and enable masks to a reply byte.
  always_comb begin
    pend                = tgt_irq & en_reg;
    rd_pend             = '0;
    rd_pend[NTGT-1:0]   = pend;
    rd_en               = '0;
    rd_en[NTGT-1:0]     = en_reg;
  end

  // Command/data handling; only the first data byte after a command acts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en_reg    <= '1;
      iack_reg  <= '0;
      op_reg    <= ICTL_READ;
      rdata_reg <= 8'hFF;
      armed_reg <= 1'b0;
      irq_reg   <= 1'b0;
    end else begin
      iack_reg <= '0;
      irq_reg  <= |pend;
      if (cmd_strobe) begin
        op_reg    <= din;
        armed_reg <= ictl_cmd_valid(din);
        case (din)
          ICTL_READ:  rdata_reg <= rd_pend;
          ICTL_GETEN: rdata_reg <= rd_en;
          default:    rdata_reg <= 8'hFF;
        endcase
      end else if (data_strobe && armed_reg) begin
        armed_reg <= 1'b0;
        case (op_reg)
          ICTL_ACK:   iack_reg <= din[NTGT-1:0];
          ICTL_SETEN: en_reg   <= din[NTGT-1:0];
          default:    ;
        endcase
      end
    end
  end

  assign rdata    = rdata_reg;
  assign tgt_iack = iack_reg;
  assign mcu_irq  = irq_reg;

endmodule

// File: rtl/mcu_target_arb.sv
// MCU byte-link arbiter: decodes the target-ID byte of each message, steers
// strobes/data to the selected target and muxes its reply back to the MCU.
module mcu_target_arb
  import mcu_target_arb_pkg::*;
#(
  parameter int         NTGT   = 4,
  parameter logic [7:0] IRQ_ID = IRQ_ID_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mcu_strobe,
  input  logic              mcu_start,
  input  logic [7:0]        mcu_din,
  output logic [7:0]        mcu_dout,
  output logic              mcu_irq,
  output logic [NTGT-1:0]   tgt_strobe,
  output logic [NTGT-1:0]   tgt_start,
  output logic [7:0]        tgt_din,
  input  logic [8*NTGT-1:0] tgt_dout,
  input  logic [NTGT-1:0]   tgt_irq,
  output logic [NTGT-1:0]   tgt_iack
);

  localparam int         SEL_W   = (NTGT > 1) ? $clog2(NTGT) : 1;
  localparam logic [7:0] NTGT_ID = 8'(NTGT);

  arb_state_t       state_reg, state_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic             fwd, fwd_start, ictl_cmd_stb, ictl_data_stb;
  logic [NTGT-1:0]  sel_hot;
  logic [7:0]       tgt_byte [NTGT];
  logic [7:0]       ictl_rdata;
  logic [7:0]       mcu_dout_reg, mcu_dout_next;
  logic [NTGT-1:0]  tgt_strobe_reg, tgt_start_reg;
  logic [7:0]       tgt_din_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NTGT; gi++) begin : g_tgt
      assign tgt_byte[gi] = tgt_dout[8*gi +: 8];
      assign sel_hot[gi]  = (sel_reg == SEL_W'(gi));
    end
  endgenerate

  // Decode FSM state and selected target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      sel_reg   <= '0;
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
    end
  end

  // Next state; a start byte re-decodes from any state and is never forwarded.
  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    fwd           = 1'b0;
    fwd_start     = 1'b0;
    ictl_cmd_stb  = 1'b0;
    ictl_data_stb = 1'b0;
    if (mcu_strobe) begin
      if (mcu_start) begin
        if (mcu_din < NTGT_ID) begin
          sel_next   = mcu_din[SEL_W-1:0];
          state_next = ST_CMD;
        end else if (mcu_din == IRQ_ID) begin
          state_next = ST_ICTL_CMD;
        end else begin
          state_next = ST_DISCARD;
        end
      end else begin
        case (state_reg)
          ST_CMD: begin
            fwd        = 1'b1;
            fwd_start  = 1'b1;
            state_next = ST_FWD;
          end
          ST_FWD:       fwd = 1'b1;
          ST_ICTL_CMD: begin
            ictl_cmd_stb = 1'b1;
            state_next   = ictl_cmd_valid(mcu_din) ? ST_ICTL_DATA : ST_DISCARD;
          end
          ST_ICTL_DATA: ictl_data_stb = 1'b1;
          default:      ;
        endcase
      end
    end
  end

  // Reply source: selected target while forwarding, controller readback, else FF.
  always_comb begin
    mcu_dout_next = 8'hFF;
    case (state_reg)
      ST_CMD, ST_FWD: mcu_dout_next = tgt_byte[sel_reg];
      ST_ICTL_DATA:   mcu_dout_next = ictl_rdata;
      default:        mcu_dout_next = 8'hFF;
    endcase
  end

  // Registered target strobes/data and MCU reply byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_strobe_reg <= '0;
      tgt_start_reg  <= '0;
      tgt_din_reg    <= '0;
      mcu_dout_reg   <= 8'hFF;
    end else begin
      tgt_strobe_reg <= fwd ? sel_hot : '0;
      tgt_start_reg  <= fwd_start ? sel_hot : '0;
      if (fwd) tgt_din_reg <= mcu_din;
      mcu_dout_reg   <= mcu_dout_next;
    end
  end

  mcu_irq_ctl #(.NTGT(NTGT)) u_irq_ctl (
    .clk         (clk),
    .reset       (reset),
    .cmd_strobe  (ictl_cmd_stb),
    .data_strobe (ictl_data_stb),
    .din         (mcu_din),
    .tgt_irq     (tgt_irq),
    .rdata       (ictl_rdata),
    .tgt_iack    (tgt_iack),
    .mcu_irq     (mcu_irq)
  );

  assign tgt_strobe = tgt_strobe_reg;
  assign tgt_start  = tgt_start_reg;
  assign tgt_din    = tgt_din_reg;
  assign mcu_dout   = mcu_dout_reg;

endmodule

// File: tb/tb_mcu_target_arb.sv
// Directed bench for mcu_target_arb with a scoreboard of forwarded bytes and acks.
module tb_mcu_target_arb;

  localparam int NTGT = 4;

  typedef struct packed {
    logic [2:0] tgt;
    logic       start;
    logic [7:0] din;
  } fwd_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              mcu_strobe;
  logic              mcu_start;
  logic [7:0]        mcu_din;
  logic [7:0]        mcu_dout;
  logic              mcu_irq;
  logic [NTGT-1:0]   tgt_strobe;
  logic [NTGT-1:0]   tgt_start;
  logic [7:0]        tgt_din;
  logic [8*NTGT-1:0] tgt_dout;
  logic [NTGT-1:0]   tgt_irq;
  logic [NTGT-1:0]   tgt_iack;

  logic [7:0] t0_dout;
  int         t0_cnt;
  int         vectors = 0;
  int         miscompares = 0;

  fwd_t            exp_q[$];
  logic [NTGT-1:0] iack_q[$];

  always #5 clk = ~clk;

  assign tgt_dout = {8'h13, 8'h12, 8'h11, t0_dout};

  mcu_target_arb #(.NTGT(NTGT)) dut (
    .clk        (clk),
    .reset      (reset),
    .mcu_strobe (mcu_strobe),
    .mcu_start  (mcu_start),
    .mcu_din    (mcu_din),
    .mcu_dout   (mcu_dout),
    .mcu_irq    (mcu_irq),
    .tgt_strobe (tgt_strobe),
    .tgt_start  (tgt_start),
    .tgt_din    (tgt_din),
    .tgt_dout   (tgt_dout),
    .tgt_irq    (tgt_irq),
    .tgt_iack   (tgt_iack)
  );

  // Target 0 model: reply 5C, switching to 42 on its second strobe.
  always @(posedge clk) begin
    if (tgt_strobe[0]) begin
      t0_cnt <= t0_cnt + 1;
      if (t0_cnt == 1) t0_dout <= 8'h42;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic st);
    @(negedge clk);
    mcu_strobe = 1'b1;
    mcu_start  = st;
    mcu_din    = b;
    @(negedge clk);
    mcu_strobe = 1'b0;
    mcu_start  = 1'b0;
    repeat (3) @(negedge clk);
    $display("tx start=%0d byte=%h mcu_dout=%h mcu_irq=%0d", st, b, mcu_dout, mcu_irq);
  endtask

  task automatic exp_fwd(input int t, input logic st, input logic [7:0] b);
    fwd_t e;
    e.tgt   = 3'(t);
    e.start = st;
    e.din   = b;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every target strobe / ack pulse pops one expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NTGT; i++) begin
        if (tgt_strobe[i]) begin
          fwd_t got;
          got.tgt   = 3'(i);
          got.start = tgt_start[i];
          got.din   = tgt_din;
          vectors++;
          assert (exp_q.size() > 0) else begin
            miscompares++;
            $error("FAIL fwd_extra: observed tgt %0d start %0d din %h expected no strobe",
                   i, tgt_start[i], tgt_din);
          end
          if (exp_q.size() > 0) check("fwd", 32'(got), 32'(exp_q.pop_front()));
        end
      end
      if (|tgt_start) check("start_wo_strobe", 32'(tgt_start & ~tgt_strobe), 32'd0);
      if (|tgt_iack) begin
        vectors++;
        assert (iack_q.size() > 0) else begin
          miscompares++;
          $error("FAIL iack_extra: observed %b expected none", tgt_iack);
        end
        if (iack_q.size() > 0) check("iack", 32'(tgt_iack), 32'(iack_q.pop_front()));
      end
    end
  end

  initial begin
    reset      = 1'b1;
    mcu_strobe = 1'b0;
    mcu_start  = 1'b0;
    mcu_din    = 8'h00;
    tgt_irq    = '0;
    t0_dout    = 8'h5C;
    t0_cnt     = 0;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(mcu_dout), 32'hFF);
    check("rst_irq", 32'(mcu_irq), 32'd0);
    check("rst_strobe", 32'(tgt_strobe), 32'd0);
    check("rst_start", 32'(tgt_start), 32'd0);
    check("rst_iack", 32'(tgt_iack), 32'd0);
    check("rst_din", 32'(tgt_din), 32'd0);
    reset = 1'b0;

    // Non-start strobe in IDLE is ignored.
    send(8'h77, 1'b0);
    check("idle_dout", 32'(mcu_dout), 32'hFF);

    // Message to target 1.
    send(8'h01, 1'b1);
    exp_fwd(1, 1'b1, 8'h03); send(8'h03, 1'b0);
    exp_fwd(1, 1'b0, 8'h00); send(8'h00, 1'b0);
    exp_fwd(1, 1'b0, 8'h1F); send(8'h1F, 1'b0);
    check("t1_reply", 32'(mcu_dout), 32'h11);

    // Target 0 reply changes after its second strobe.
    send(8'h00, 1'b1);
    exp_fwd(0, 1'b1, 8'hAA); send(8'hAA, 1'b0);
    check("t0_reply_a", 32'(mcu_dout), 32'h5C);
    exp_fwd(0, 1'b0, 8'h11); send(8'h11, 1'b0);
    check("t0_reply_b", 32'(mcu_dout), 32'h42);

    // Interrupts: pending read, ack, irq merge.
    @(negedge clk);
    tgt_irq = 4'b0101;
    @(negedge clk);
    check("irq_merge", 32'(mcu_irq), 32'd1);
    send(8'hF0, 1'b1); send(8'h00, 1'b0);
    check("pend_read", 32'(mcu_dout), 32'h05);
    send(8'hF0, 1'b1); send(8'h01, 1'b0);
    iack_q.push_back(4'b0100); send(8'h04, 1'b0);
    tgt_irq[2] = 1'b0;
    send(8'h04, 1'b0);  // second data byte: no further ack
    check("irq_still_set", 32'(mcu_irq), 32'd1);

    // Enable mask write/readback.
    send(8'hF0, 1'b1); send(8'h02, 1'b0); send(8'h00, 1'b0);
    check("irq_masked", 32'(mcu_irq), 32'd0);
    send(8'hF0, 1'b1); send(8'h03, 1'b0);
    check("en_read0", 32'(mcu_dout), 32'h00);
    send(8'hF0, 1'b1); send(8'h02, 1'b0); send(8'h0A, 1'b0);
    send(8'hF0, 1'b1); send(8'h03, 1'b0);
    check("en_readA", 32'(mcu_dout), 32'h0A);
    check("irq_reenabled", 32'(mcu_irq), 32'd0);  // irq0 pending, en bit0 clear

    // Unknown target ID and unknown controller command are discarded.
    send(8'h07, 1'b1); send(8'h55, 1'b0); send(8'h66, 1'b0);
    check("discard_id", 32'(mcu_dout), 32'hFF);
    send(8'hF0, 1'b1); send(8'h09, 1'b0); send(8'h01, 1'b0);
    check("discard_cmd", 32'(mcu_dout), 32'hFF);

    // Start mid-message retargets immediately.
    send(8'h01, 1'b1);
    exp_fwd(1, 1'b1, 8'h30); send(8'h30, 1'b0);
    exp_fwd(1, 1'b0, 8'h31); send(8'h31, 1'b0);
    send(8'h02, 1'b1);
    exp_fwd(2, 1'b1, 8'h40); send(8'h40, 1'b0);
    exp_fwd(2, 1'b0, 8'h41); send(8'h41, 1'b0);
    check("t2_reply", 32'(mcu_dout), 32'h12);

    // Reset mid-message: immediate reset values, enable mask restored.
    send(8'h01, 1'b1);
    exp_fwd(1, 1'b1, 8'h50); send(8'h50, 1'b0);
    reset = 1'b1;
    #1;
    check("amid_dout", 32'(mcu_dout), 32'hFF);
    check("amid_irq", 32'(mcu_irq), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_en_ones", 32'(mcu_irq), 32'd1);
    send(8'h51, 1'b0);
    check("post_rst_dout", 32'(mcu_dout), 32'hFF);

    repeat (4) @(negedge clk);
    check("sb_fwd_drain", 32'(exp_q.size()), 32'd0);
    check("sb_iack_drain", 32'(iack_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
